// File: rtl/ins_encoder.sv
// Packs opcode/register/funct/immediate fields into a 32-bit RV64 instruction word.
// The encoded words pass through a small FIFO with valid/ready handshakes on both sides.
module ins_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [6:0]       OPCODE,
    input  logic [4:0]       RD,
    input  logic [4:0]       RS1,
    input  logic [4:0]       RS2,
    input  logic [2:0]       FUNCT3,
    input  logic [6:0]       FUNCT7,
    input  logic [31:0]      IMM,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      INS,
    output logic [2:0]       TYPE,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] ENC_COUNT
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] NTYPE = 3'd0;
    localparam logic [2:0] RTYPE = 3'd1;
    localparam logic [2:0] ITYPE = 3'd2;
    localparam logic [2:0] STYPE = 3'd3;
    localparam logic [2:0] BTYPE = 3'd4;
    localparam logic [2:0] UTYPE = 3'd5;
    localparam logic [2:0] JTYPE = 3'd6;

    typedef struct packed {
        logic [31:0] ins;
        logic [2:0]  ty;
        logic        ill;
    } entry_t;

    logic [2:0] ty;
    logic       known;
    logic [31:0] word;
    logic        ill;
    entry_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic          full, empty, push, pop;

    always_comb begin
        ty    = NTYPE;
        known = 1'b1;
        case (OPCODE)
            7'b0110111, 7'b0010111:                         ty = UTYPE;
            7'b1101111:                                     ty = JTYPE;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0011011, 7'b1110011:                         ty = ITYPE;
            7'b1100011:                                     ty = BTYPE;
            7'b0100011:                                     ty = STYPE;
            7'b0110011, 7'b0111011, 7'b0101111:             ty = RTYPE;
            7'b0001111:                                     ty = NTYPE;
            default:                                        known = 1'b0;
        endcase
    end

    // Immediate range checks: upper bits must be a pure sign extension.
    always_comb begin
        word = {25'd0, OPCODE};
        ill  = !known;
        case (ty)
            RTYPE: word = {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE};
            ITYPE: begin
                word = {IMM[11:0], RS1, FUNCT3, RD, OPCODE};
                ill  = !(&IMM[31:11] || !(|IMM[31:11]));
            end
            STYPE: begin
                word = {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE};
                ill  = !(&IMM[31:11] || !(|IMM[31:11]));
            end
            BTYPE: begin
                word = {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE};
                ill  = !(&IMM[31:12] || !(|IMM[31:12])) || IMM[0];
            end
            UTYPE: begin
                word = {IMM[31:12], RD, OPCODE};
                ill  = |IMM[11:0];
            end
            JTYPE: begin
                word = {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE};
                ill  = !(&IMM[31:20] || !(|IMM[31:20])) || IMM[0];
            end
            default: ;
        endcase
    end

    assign full     = (occ == (AW+1)'(DEPTH));
    assign empty    = (occ == '0);
    assign IN_READY = !full;
    assign push     = IN_VALID && !full;
    assign pop      = !empty && OUT_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            ENC_COUNT <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                ENC_COUNT <= ENC_COUNT + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= '{ins: word, ty: ty, ill: ill};
    end

    // An empty FIFO presents the reset values rather than a stale entry.
    assign OUT_VALID = !empty;
    assign INS       = empty ? 32'd0 : mem[rd_ptr].ins;
    assign TYPE      = empty ? NTYPE : mem[rd_ptr].ty;
    assign ILLEGAL   = empty ? 1'b0  : mem[rd_ptr].ill;
endmodule

// File: tb/tb_ins_encoder.sv
// Directed bench for ins_encoder: a queue-based model checked every cycle,
// plus literal expectations from hand-encoded instructions.
module tb_ins_encoder;
    localparam int DEPTH = 2;
    localparam logic [2:0] NT = 3'd0, RT = 3'd1, IT = 3'd2, ST = 3'd3,
                           BT = 3'd4, UT = 3'd5, JT = 3'd6;

    logic CLK = 0, RST = 1;
    logic IN_VALID = 0, IN_READY, OUT_VALID, OUT_READY = 0, ILLEGAL;
    logic [6:0] OPCODE = 0, FUNCT7 = 0;
    logic [4:0] RD = 0, RS1 = 0, RS2 = 0;
    logic [2:0] FUNCT3 = 0, TYPE;
    logic [31:0] IMM = 0, INS;
    logic [15:0] ENC_COUNT;

    ins_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2), .FUNCT3(FUNCT3),
        .FUNCT7(FUNCT7), .IMM(IMM), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .INS(INS), .TYPE(TYPE), .ILLEGAL(ILLEGAL), .ENC_COUNT(ENC_COUNT));

    always #5 CLK = ~CLK;

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [31:0] ins; logic [2:0] ty; logic ill; } exp_t;
    exp_t q[$];
    logic [15:0] cnt = 0;

    function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                   input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        exp_t e;
        int si = int'(imm);
        logic [31:0] base = {25'd0, op};
        case (op)
            7'h37, 7'h17: e.ty = UT;
            7'h6F: e.ty = JT;
            7'h67, 7'h03, 7'h13, 7'h1B, 7'h73: e.ty = IT;
            7'h63: e.ty = BT;
            7'h23: e.ty = ST;
            7'h33, 7'h3B, 7'h2F: e.ty = RT;
            default: e.ty = NT;
        endcase
        e.ill = 0;
        e.ins = base;
        case (e.ty)
            RT: e.ins = base | 32'(f7) << 25 | 32'(rs2) << 20 | 32'(rs1) << 15 | 32'(f3) << 12 | 32'(rd) << 7;
            IT: begin
                e.ins = base | (imm & 32'hFFF) << 20 | 32'(rs1) << 15 | 32'(f3) << 12 | 32'(rd) << 7;
                e.ill = si < -2048 || si > 2047;
            end
            ST: begin
                e.ins = base | ((imm >> 5) & 32'h7F) << 25 | 32'(rs2) << 20 | 32'(rs1) << 15
                      | 32'(f3) << 12 | (imm & 32'h1F) << 7;
                e.ill = si < -2048 || si > 2047;
            end
            BT: begin
                e.ins = base | ((imm >> 12) & 1) << 31 | ((imm >> 5) & 32'h3F) << 25 | 32'(rs2) << 20
                      | 32'(rs1) << 15 | 32'(f3) << 12 | ((imm >> 1) & 32'hF) << 8 | ((imm >> 11) & 1) << 7;
                e.ill = si < -4096 || si > 4095 || (imm % 2 == 1);
            end
            UT: begin
                e.ins = base | (imm & 32'hFFFFF000) | 32'(rd) << 7;
                e.ill = (imm % 4096) != 0;
            end
            JT: begin
                e.ins = base | ((imm >> 20) & 1) << 31 | ((imm >> 1) & 32'h3FF) << 21
                      | ((imm >> 11) & 1) << 20 | ((imm >> 12) & 32'hFF) << 12 | 32'(rd) << 7;
                e.ill = si < -(1 << 20) || si >= (1 << 20) || (imm % 2 == 1);
            end
            default: e.ill = (op != 7'h0F);
        endcase
        return e;
    endfunction

    // Model update on the clock edge, from the model's own occupancy.
    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
            cnt <= 0;
        end else begin
            logic acc, pp;
            acc = IN_VALID && (q.size() < DEPTH);
            pp  = (q.size() != 0) && OUT_READY;
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(model(OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM));
                cnt <= cnt + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            chk("out_valid", 32'(OUT_VALID), 32'(q.size() != 0));
            chk("in_ready", 32'(IN_READY), 32'(q.size() < DEPTH));
            chk("enc_count", 32'(ENC_COUNT), 32'(cnt));
            if (q.size() != 0) begin
                chk("ins", INS, q[0].ins);
                chk("type", 32'(TYPE), 32'(q[0].ty));
                chk("illegal", 32'(ILLEGAL), 32'(q[0].ill));
            end
        end
    end

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                           input logic [2:0] f3, input logic [31:0] imm);
        OPCODE = op; RD = rd; RS1 = rs1; RS2 = rs2; FUNCT3 = f3; FUNCT7 = 0; IMM = imm;
        IN_VALID = 1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge with IN_VALID low.
    task automatic wait_accept();
        logic ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK); ok = IN_READY;
            @(posedge CLK); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        IN_VALID = 0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1 RST = 1; IN_VALID = 0;
        @(posedge CLK); #1 RST = 0;
    endtask

    // Single word with an empty FIFO: must appear one cycle after accept.
    task automatic single(input string nm, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                          input logic [2:0] f3, input logic [31:0] imm,
                          input logic [31:0] e_ins, input logic [2:0] e_ty, input logic e_ill);
        OUT_READY = 0;
        set_req(op, rd, rs1, rs2, f3, imm);
        wait_accept();
        @(negedge CLK);
        chk({nm, "_valid"}, 32'(OUT_VALID), 1);
        chk({nm, "_ins"}, INS, e_ins);
        chk({nm, "_type"}, 32'(TYPE), 32'(e_ty));
        chk({nm, "_ill"}, 32'(ILLEGAL), 32'(e_ill));
        @(posedge CLK); #1 OUT_READY = 1;
        @(posedge CLK); #1 OUT_READY = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        chk("rst_out_valid", 32'(OUT_VALID), 0);
        chk("rst_ins", INS, 0);
        chk("rst_type", 32'(TYPE), 32'(NT));
        chk("rst_illegal", 32'(ILLEGAL), 0);
        chk("rst_count", 32'(ENC_COUNT), 0);
        chk("rst_in_ready", 32'(IN_READY), 1);
        @(posedge CLK); #1;

        single("addi",   7'h13, 1, 0, 0, 3'b000, 32'd5,          32'h00500093, IT, 0);
        single("sw",     7'h23, 0, 1, 2, 3'b010, 32'd8,          32'h0020A423, ST, 0);
        single("lui",    7'h37, 5, 0, 0, 3'b000, 32'h12345000,   32'h123452B7, UT, 0);
        single("jal",    7'h6F, 1, 0, 0, 3'b000, 32'h800,        32'h001000EF, JT, 0);
        single("jal_odd",7'h6F, 1, 0, 0, 3'b000, 32'h801,        32'h001000EF, JT, 1);
        single("br_odd", 7'h63, 0, 0, 0, 3'b000, 32'd3,          32'h00000163, BT, 1);
        single("addi_big",7'h13,0, 0, 0, 3'b000, 32'h800,        32'h80000013, IT, 1);
        single("op0",    7'h00, 0, 0, 0, 3'b000, 32'd0,          32'h00000000, NT, 1);
        single("add",    7'h33, 3, 4, 5, 3'b000, 32'd0,          32'h005201B3, RT, 0);
        single("beq_neg",7'h63, 0, 1, 2, 3'b000, 32'hFFFFFFFC,   32'hFE208EE3, BT, 0);

        // Backpressure: two words fill the FIFO, the third waits.
        do_reset();
        OUT_READY = 0;
        set_req(7'h13, 1, 0, 0, 0, 32'd1); wait_accept();
        set_req(7'h13, 2, 0, 0, 0, 32'd2); wait_accept();
        set_req(7'h13, 3, 0, 0, 0, 32'd3);
        repeat (3) begin
            @(negedge CLK);
            chk("bp_in_ready", 32'(IN_READY), 0);
            chk("bp_hold_ins", INS, 32'h00100093);
        end
        @(posedge CLK); #1 OUT_READY = 1;
        @(posedge CLK);
        @(negedge CLK);
        chk("bp_ready_after_pop", 32'(IN_READY), 1);
        chk("bp_second_word", INS, 32'h00200113);
        @(posedge CLK); #1 IN_VALID = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("bp_count", 32'(ENC_COUNT), 3);
        chk("bp_drained", 32'(OUT_VALID), 0);

        // Reset with two words buffered.
        @(posedge CLK); #1 OUT_READY = 0;
        set_req(7'h13, 1, 0, 0, 0, 32'd1); wait_accept();
        set_req(7'h13, 2, 0, 0, 0, 32'd2); wait_accept();
        RST = 1;
        @(posedge CLK); #1 RST = 0;
        @(negedge CLK);
        chk("mid_rst_valid", 32'(OUT_VALID), 0);
        chk("mid_rst_count", 32'(ENC_COUNT), 0);
        chk("mid_rst_ready", 32'(IN_READY), 1);

        // Counter wrap: stream 65535 accepts, then one more.
        @(posedge CLK); #1 OUT_READY = 1;
        set_req(7'h13, 1, 0, 0, 0, 32'd1);
        repeat (65535) @(posedge CLK);
        #1 IN_VALID = 0;
        @(negedge CLK);
        chk("cnt_ffff", 32'(ENC_COUNT), 32'hFFFF);
        @(posedge CLK); #1;
        set_req(7'h37, 7, 0, 0, 0, 32'hFFFFF000); wait_accept();
        @(negedge CLK);
        chk("cnt_wrap", 32'(ENC_COUNT), 0);
        chk("wrap_lui", INS, 32'hFFFFF3B7);
        repeat (3) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ins_encoder.md
Name: ins_encoder

Overview:
- Inverse of the pipeline's opcode-to-type decode: packs opcode, register indices, funct fields and a 32-bit immediate into a 32-bit RV64 instruction word.
- Derives the format type from the opcode internally and flags illegal combinations.
- Used by the debug/instruction-injection path and by self-test sequencers that feed the fetch stage.
- Buffered with valid/ready on both sides.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the accepted-instruction counter.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- IN_VALID  in  1  request valid
- IN_READY  out  1  request accepted when IN_VALID and IN_READY are both high
- OPCODE  in  7  major opcode
- RD  in  5  destination register
- RS1  in  5  source register 1
- RS2  in  5  source register 2
- FUNCT3  in  3  funct3 field
- FUNCT7  in  7  funct7 field
- IMM  in  32  immediate, byte-offset/value form, sign-extended
- OUT_VALID  out  1  encoded word valid
- OUT_READY  in  1  consumer ready
- INS  out  32  encoded instruction
- TYPE  out  3  format type, using the shared pipeline-params type constants
- ILLEGAL  out  1  encoding error flag for the word on INS
- ENC_COUNT  out  CNT_W  number of accepted requests, wraps

Behaviour:
- Reset: FIFO empty, OUT_VALID=0, INS=0, TYPE=ntype, ILLEGAL=0, ENC_COUNT=0. IN_READY=1 in the cycle after RST deasserts.
- Type map:
  - lui 0110111, auipc 0010111 -> utype
  - jal 1101111 -> jtype
  - jalr 1100111, load 0000011, op-imm 0010011, op-imm-32 0011011, system 1110011 -> itype
  - branch 1100011 -> btype
  - store 0100011 -> stype
  - op 0110011, op-32 0111011, amo 0101111 -> rtype
  - fence 0001111 and all other opcodes -> ntype
- Packing:
  - rtype: {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE}
  - itype: {IMM[11:0], RS1, FUNCT3, RD, OPCODE}
  - stype: {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE}
  - btype: {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE}
  - utype: {IMM[31:12], RD, OPCODE}
  - jtype: {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE}
  - ntype: {25'd0, OPCODE}
- ILLEGAL=1 when any of the following holds:
  - itype or stype with IMM[31:11] not all equal.
  - btype with IMM[31:12] not all equal, or IMM[0]=1.
  - jtype with IMM[31:20] not all equal, or IMM[0]=1.
  - utype with IMM[11:0] nonzero.
  - opcode not in the map (fence is legal).
  Illegal words are still packed as above, enqueued and counted. No request is ever dropped.
- Encoding is combinational on the inputs. The result {INS, TYPE, ILLEGAL} is written into the FIFO on accept.
- Latency: accepted in cycle N with FIFO empty -> OUT_VALID=1 with that word in cycle N+1. No combinational input-to-output path.
- IN_READY = !full, derived from registered occupancy only. There is no dependence on OUT_READY.
- Pop occurs when OUT_VALID and OUT_READY are both high.
- Simultaneous push and pop:
  - Not full: occupancy unchanged, order preserved.
  - Full: IN_READY=0, so only the pop happens; IN_READY rises the next cycle.
- Output stability: while OUT_VALID=1 and OUT_READY=0, INS, TYPE and ILLEGAL hold stable.
- Pointers: read and write pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- ENC_COUNT increments by 1 per accept and wraps 2^CNT_W-1 -> 0.
- RST mid-operation: FIFO contents discarded, counter cleared; same values as reset.

Test Plan:
- op-imm, RD=1, RS1=0, FUNCT3=0, IMM=5 -> INS=0x00500093, TYPE=itype, ILLEGAL=0, OUT_VALID one cycle after accept.
- store, RS1=1, RS2=2, FUNCT3=010, IMM=8 -> INS=0x0020A423, TYPE=stype. Then lui, RD=5, IMM=0x12345000 -> INS=0x123452B7, TYPE=utype.
- jal, RD=1, IMM=0x800 -> INS=0x001000EF, TYPE=jtype, ILLEGAL=0. Same request with IMM=0x801 -> ILLEGAL=1.
- branch, IMM=3 -> ILLEGAL=1; op-imm, IMM=0x800 -> ILLEGAL=1; OPCODE=0000000 -> TYPE=ntype, ILLEGAL=1, INS=0x00000000.
- Backpressure:
  - Hold OUT_READY=0 and push 3 requests: IN_READY drops after 2 accepts, outputs stay stable.
  - Release OUT_READY: words emerge in order, and IN_READY=1 the cycle after the first pop.
  - ENC_COUNT ends at 3.
- Assert RST while the FIFO holds 2 words -> next cycle OUT_VALID=0, ENC_COUNT=0, IN_READY=1. Preload ENC_COUNT to 0xFFFF via accepts, then one more accept -> 0x0000.
